// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions for the encoder and decoder.
package ham_pkg;

  localparam int unsigned DataWidth = 4;
  localparam int unsigned CwWidth   = 7;

  // Codeword bit positions (b0 is transmitted first).
  localparam int unsigned PosP1 = 0;
  localparam int unsigned PosP2 = 1;
  localparam int unsigned PosD0 = 2;
  localparam int unsigned PosP4 = 3;
  localparam int unsigned PosD1 = 4;
  localparam int unsigned PosD2 = 5;
  localparam int unsigned PosD3 = 6;

  // Index of the final serialised bit.
  localparam logic [2:0] LastBit = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } ham_state_e;

endpackage

// File: rtl/ham_parity_gen.sv
// Combinational Hamming(7,4) codeword builder.
module ham_parity_gen
  import ham_pkg::*;
(
  input  logic [DataWidth-1:0] data_i,
  output logic [CwWidth-1:0]   code_o
);

  // Place data bits and even parities over the decoder's check groups.
  always_comb begin
    code_o        = '0;
    code_o[PosD0] = data_i[0];
    code_o[PosD1] = data_i[1];
    code_o[PosD2] = data_i[2];
    code_o[PosD3] = data_i[3];
    code_o[PosP1] = data_i[0] ^ data_i[1] ^ data_i[3];
    code_o[PosP2] = data_i[0] ^ data_i[2] ^ data_i[3];
    code_o[PosP4] = data_i[1] ^ data_i[2] ^ data_i[3];
  end

endmodule

// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with optional single-bit error injection and a
// LSB-first serialiser; an optional idle gap follows every frame.
module ham_encoder_tx
  import ham_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 inj_en,
  input  logic [2:0]           inj_pos,
  output logic [CwWidth-1:0]   enc_ham_data,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 ser_sof,
  output logic                 ser_eof,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam bit         HasGap  = (GAP_CYCLES != 0);
  localparam logic [3:0] GapLast = HasGap ? 4'(GAP_CYCLES - 1) : 4'd0;

  ham_state_e         state_q, state_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [CwWidth-1:0] code_q, code_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic [CwWidth-1:0] parity_code;
  logic [CwWidth-1:0] inj_mask;
  logic               last_bit;
  logic               accept;

  ham_parity_gen u_parity_gen (
    .data_i (in_data),
    .code_o (parity_code)
  );

  // One-hot flip mask; position 0 means no injection.
  always_comb begin
    inj_mask = '0;
    if (inj_en && (inj_pos != 3'd0)) begin
      inj_mask[inj_pos - 3'd1] = 1'b1;
    end
  end

  // Serial outputs and handshake decoded from the current state.
  always_comb begin
    ser_valid = (state_q == StShift);
    last_bit  = ser_valid && (bit_idx_q == LastBit);
    ser_out   = ser_valid && code_q[bit_idx_q];
    ser_sof   = ser_valid && (bit_idx_q == 3'd0);
    ser_eof   = last_bit;
    // Without a gap the next nibble can be taken on the eof cycle.
    in_ready  = (state_q == StIdle) || (!HasGap && last_bit);
    busy      = (state_q != StIdle);
    accept    = in_valid && in_ready;
  end

  assign enc_ham_data = code_q;
  assign frame_cnt    = frame_cnt_q;

  // Next-state logic for the frame FSM, codeword and frame counter.
  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    gap_cnt_d   = gap_cnt_q;
    code_d      = code_q;
    frame_cnt_d = frame_cnt_q;

    if (accept) begin
      code_d = parity_code ^ inj_mask;
    end
    if (last_bit) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StShift;
          bit_idx_d = 3'd0;
        end
      end
      StShift: begin
        if (last_bit) begin
          bit_idx_d = 3'd0;
          if (accept) begin
            state_d = StShift;
          end else if (HasGap) begin
            state_d   = StGap;
            gap_cnt_d = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_idx_q   <= 3'd0;
      gap_cnt_q   <= 4'd0;
      code_q      <= '0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      gap_cnt_q   <= gap_cnt_d;
      code_q      <= code_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
